// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the AES round controller and its datapath.
// The master modport is the controller side; the slave modport is the datapath/consumer side.
interface aes_round_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic        ld_init;
    logic        rnd_en;
    logic        mix_en;
    logic [3:0]  round;
    logic [7:0]  rcon;
    logic        busy;
    logic [15:0] done_cnt;

    modport master (
        input  in_valid,
        input  out_ready,
        input  flush,
        output in_ready,
        output out_valid,
        output ld_init,
        output rnd_en,
        output mix_en,
        output round,
        output rcon,
        output busy,
        output done_cnt
    );

    modport slave (
        output in_valid,
        output out_ready,
        output flush,
        input  in_ready,
        input  out_valid,
        input  ld_init,
        input  rnd_en,
        input  mix_en,
        input  round,
        input  rcon,
        input  busy,
        input  done_cnt
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts a block, steps ROUNDS round-enables with the matching
// round constant, then holds the result until the consumer takes it.
module aes_round_ctrl #(
    parameter int unsigned ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_round_ctrl_if.master bus
);

    localparam logic [3:0] LastRound = 4'(ROUNDS);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRound = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_round, w_round_nxt;
    logic [7:0]  r_rcon, w_rcon_nxt;
    logic [15:0] r_done_cnt, w_done_cnt_nxt;

    logic        w_in_ready;
    logic        w_ld_init;
    logic        w_out_valid;
    logic        w_rnd_en;
    logic        w_mix_en;
    logic [7:0]  w_rcon_out;
    logic        w_handshake;

    // GF(2^8) multiply by x, reduced by the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
    endfunction

    // Handshake and datapath strobes decoded from the current state
    always_comb begin
        w_in_ready  = (r_state == StIdle) && !bus.flush;
        w_ld_init   = w_in_ready && bus.in_valid;
        w_out_valid = (r_state == StDone);
        w_rnd_en    = (r_state == StRound);
        w_mix_en    = w_rnd_en && (r_round != LastRound);
        w_rcon_out  = w_rnd_en ? r_rcon : 8'h00;
        // A flush in the same cycle cancels the handshake count
        w_handshake = w_out_valid && bus.out_ready && !bus.flush;
    end

    // Next-state logic; flush overrides every state transition
    always_comb begin
        w_state_nxt    = r_state;
        w_round_nxt    = r_round;
        w_rcon_nxt     = r_rcon;
        w_done_cnt_nxt = r_done_cnt;

        unique case (r_state)
            StIdle: begin
                if (w_ld_init) begin
                    w_state_nxt = StRound;
                    w_round_nxt = 4'd1;
                    w_rcon_nxt  = 8'h01;
                end
            end
            StRound: begin
                if (r_round == LastRound) begin
                    w_state_nxt = StDone;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                    w_rcon_nxt  = xtime(r_rcon);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_nxt = StIdle;
                    w_round_nxt = 4'd0;
                    w_rcon_nxt  = 8'h01;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_round_nxt = 4'd0;
                w_rcon_nxt  = 8'h01;
            end
        endcase

        if (w_handshake) begin
            w_done_cnt_nxt = r_done_cnt + 16'd1;
        end

        if (bus.flush) begin
            w_state_nxt = StIdle;
            w_round_nxt = 4'd0;
            w_rcon_nxt  = 8'h01;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_round    <= 4'd0;
            r_rcon     <= 8'h01;
            r_done_cnt <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_round    <= w_round_nxt;
            r_rcon     <= w_rcon_nxt;
            r_done_cnt <= w_done_cnt_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.ld_init   = w_ld_init;
    assign bus.out_valid = w_out_valid;
    assign bus.rnd_en    = w_rnd_en;
    assign bus.mix_en    = w_mix_en;
    assign bus.round     = r_round;
    assign bus.rcon      = w_rcon_out;
    assign bus.busy      = (r_state != StIdle);
    assign bus.done_cnt  = r_done_cnt;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 10, number of cipher rounds per block; legal range 2..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  new block (plaintext+key) presented to the datapath.
REQ-005 in_ready  output  1  controller can accept a block.
REQ-006 out_valid  output  1  datapath state register holds a finished ciphertext.
REQ-007 out_ready  input  1  consumer accepts ciphertext.
REQ-008 flush  input  1  synchronous abort of the block in flight.
REQ-009 ld_init  output  1  datapath loads state <= plaintext XOR key and key register <= key.
REQ-010 rnd_en  output  1  datapath loads state with one round result and key with the next round key.
REQ-011 mix_en  output  1  selects the MixColumns result (1) or bypass (0) for this round.
REQ-012 round  output  4  current round index.
REQ-013 rcon  output  8  round constant for this cycle's key expansion.
REQ-014 busy  output  1  block in flight (INIT accepted, not yet drained).
REQ-015 done_cnt  output  16  count of completed output handshakes.

Function
REQ-016 The FSM SHALL have states IDLE, ROUND, DONE; state, round, rcon register and done_cnt are registered.
REQ-017 IDLE: in_ready=1 unless flush=1; ld_init = in_valid & in_ready (combinational, same cycle); on ld_init go to ROUND with round=1, rcon register=0x01.
REQ-018 ROUND: rnd_en=1 every cycle; mix_en = (round != ROUNDS); rcon output = rcon register.
REQ-019 ROUND, round<ROUNDS: round <= round+1, rcon <= xtime(rcon) = (rcon<<1) XOR (rcon[7] ? 0x1B : 0x00), 8-bit truncation.
REQ-020 ROUND, round==ROUNDS: go to DONE; round and rcon register hold.
REQ-021 Outside ROUND: rnd_en=0, mix_en=0, rcon output=0x00; ld_init=0 outside IDLE.
REQ-022 DONE: out_valid=1; holds until out_ready=1, then IDLE next cycle with round=0, rcon register=0x01; in_ready=0 in DONE (no accept in DONE).
REQ-023 Latency: ld_init in cycle T gives rnd_en in T+1..T+ROUNDS and out_valid first in T+ROUNDS+1; minimum block period ROUNDS+2 cycles with out_ready held 1.
REQ-024 Sequence for ROUNDS=10: rcon = 01,02,04,08,10,20,40,80,1B,36 in rounds 1..10; mix_en=0 only in round 10.
REQ-025 busy = 1 in ROUND and DONE, 0 in IDLE.
REQ-026 done_cnt SHALL increment by 1 on each cycle with out_valid & out_ready, wrapping 0xFFFF -> 0x0000.
REQ-027 flush=1 in any state: next state IDLE, round=0, rcon register=0x01; in that cycle in_ready=0, ld_init=0, and a pending out_valid/out_ready handshake is not counted; rnd_en/mix_en follow REQ-018 for that cycle.
REQ-028 in_valid while not in IDLE SHALL be ignored; out_ready outside DONE SHALL be ignored.
REQ-029 Handshake stability: once out_valid=1 it SHALL stay 1 until out_ready=1 or flush=1.

Reset
REQ-030 rst_n=0 sampled on a rising edge: state=IDLE, round=0, rcon register=0x01, done_cnt=0x0000; rst_n overrides flush and all handshakes.
REQ-031 Outputs after reset (rst_n=1, no inputs): in_ready=1, out_valid=0, ld_init=0, rnd_en=0, mix_en=0, round=0, rcon=0x00, busy=0, done_cnt=0.
REQ-032 rst_n low mid-block aborts the block; no out_valid for that block appears afterwards.

Verification
REQ-033 Single block, ROUNDS=10: in_valid=1 at cycle 0 -> ld_init=1 cycle 0; rnd_en cycles 1..10 with round 1..10 and rcon 01..36 per REQ-024; mix_en=0 only cycle 10; out_valid=1 at cycle 11.
REQ-034 Output backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, in_ready stays 0, in_valid ignored; out_ready=1 -> IDLE next cycle, done_cnt=1.
REQ-035 Back-to-back: in_valid and out_ready held 1 -> ld_init pulses every 12 cycles; done_cnt increments every 12 cycles.
REQ-036 Flush at round 5 -> IDLE next cycle, round=0, no out_valid, done_cnt unchanged; next block runs the full REQ-033 sequence.
REQ-037 Reset at round 7 with out_ready=1 -> all REQ-031 values next cycle; flush and in_valid asserted with rst_n=0 have no effect.
REQ-038 Counter wrap: done_cnt preloaded to 0xFFFF via 65535 blocks (or ROUNDS=2 for speed) -> next output handshake gives done_cnt=0x0000.
